// File: rtl/yuv_pkg.sv
// rtl/yuv_pkg.sv - shared types and chroma helper for the 422->444 converter
package yuv_pkg;

  localparam int PAIR_W = 32;
  localparam int PX_W   = 32;

  // Field order is MSB first, so y0 lands in byte 0 of the packed pair.
  typedef struct packed {
    logic [7:0] v;
    logic [7:0] y1;
    logic [7:0] u;
    logic [7:0] y0;
  } yuv422_pair_t;

  // Field order is MSB first, so v lands in byte 0 and pad in byte 3.
  typedef struct packed {
    logic [7:0] pad;
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv444_px_t;

  // Rounded mean of two chroma samples; the 9-bit sum keeps the carry before the halving.
  function automatic logic [7:0] chroma_avg(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return 8'(s >> 1);
  endfunction

endpackage

// File: rtl/yuv_pair_expand.sv
// rtl/yuv_pair_expand.sv - expands one 422 pair into two 444 pixels
module yuv_pair_expand
  import yuv_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic [PAIR_W-1:0] pair,
  input  logic [7:0]        nxt_u,
  input  logic [7:0]        nxt_v,
  input  logic              interp,
  output logic [PX_W-1:0]   px0,
  output logic [PX_W-1:0]   px1
);

  yuv422_pair_t p;
  yuv444_px_t   even_px;
  yuv444_px_t   odd_px;

  // Even pixel always uses its own pair's chroma; odd pixel optionally averages toward the next pair.
  always_comb begin
    p          = yuv422_pair_t'(pair);
    even_px    = '{pad: PAD_BYTE, y: p.y0, u: p.u, v: p.v};
    odd_px.pad = PAD_BYTE;
    odd_px.y   = p.y1;
    odd_px.u   = interp ? chroma_avg(p.u, nxt_u) : p.u;
    odd_px.v   = interp ? chroma_avg(p.v, nxt_v) : p.v;
  end

  assign px0 = even_px;
  assign px1 = odd_px;

endmodule

// File: rtl/yuv422to444_stream.sv
// rtl/yuv422to444_stream.sv - packed Y'UV422 to Y'UV444 stream converter
module yuv422to444_stream
  import yuv_pkg::*;
#(
  parameter int         DATA_WIDTH = 64,
  parameter int         USER_WIDTH = 1,
  parameter int         DEST_WIDTH = 1,
  parameter int         CHAIN_ID   = 0,
  parameter logic [7:0] PAD_BYTE   = 8'h00
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      interp_en,
  input  logic [DATA_WIDTH-1:0]     src_t_data,
  input  logic [DATA_WIDTH/8-1:0]   src_t_strb,
  input  logic [DATA_WIDTH/8-1:0]   src_t_keep,
  input  logic                      src_t_last,
  input  logic [USER_WIDTH-1:0]     src_t_user,
  input  logic                      src_t_valid,
  output logic                      src_t_ready,
  output logic [2*DATA_WIDTH-1:0]   dst_t_data,
  output logic [2*DATA_WIDTH/8-1:0] dst_t_strb,
  output logic [2*DATA_WIDTH/8-1:0] dst_t_keep,
  output logic                      dst_t_last,
  output logic [USER_WIDTH-1:0]     dst_t_user,
  output logic [DEST_WIDTH-1:0]     dst_t_dest,
  output logic                      dst_t_valid,
  input  logic                      dst_t_ready
);

  localparam int NP = DATA_WIDTH / PAIR_W;

  logic [DATA_WIDTH-1:0]   h_data;
  logic                    h_last;
  logic [USER_WIDTH-1:0]   h_user;
  logic                    hold_vld;
  logic                    mode_q;
  logic                    line_start;

  logic                    o_free;
  logic                    h_move;
  logic                    src_fire;
  logic                    in_mode;
  logic                    direct;
  logic                    o_load;
  logic                    h_load;

  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    exp_last;
  logic [USER_WIDTH-1:0]   exp_user;
  logic                    exp_interp;
  logic [2*DATA_WIDTH-1:0] exp_px;

  assign dst_t_strb = '1;
  assign dst_t_keep = '1;

  // Handshake: H drains into O when O is free; a non-last interpolated beat also needs its successor present.
  always_comb begin
    o_free      = !dst_t_valid || dst_t_ready;
    h_move      = hold_vld && o_free && (h_last || !mode_q || src_t_valid);
    src_t_ready = !hold_vld || h_move;
    src_fire    = src_t_valid && src_t_ready;
    in_mode     = line_start ? interp_en : mode_q;
    direct      = src_fire && !hold_vld && !in_mode && o_free;
    o_load      = h_move || direct;
    h_load      = src_fire && !direct;
  end

  // Pick the beat being emitted: H when it drains, otherwise a replicate-mode beat bypassing H.
  always_comb begin
    exp_data   = h_move ? h_data : src_t_data;
    exp_last   = h_move ? h_last : src_t_last;
    exp_user   = h_move ? h_user : src_t_user;
    exp_interp = h_move && mode_q;
  end

  for (genvar i = 0; i < NP; i++) begin : g_pair
    logic [7:0] nxt_u;
    logic [7:0] nxt_v;
    if (i < NP - 1) begin : g_inner
      assign nxt_u = exp_data[PAIR_W*(i+1)+8  +: 8];
      assign nxt_v = exp_data[PAIR_W*(i+1)+24 +: 8];
    end else begin : g_edge
      // Last pair of a beat borrows pair 0 of the incoming beat, or its own chroma at end of line.
      assign nxt_u = exp_last ? exp_data[PAIR_W*i+8  +: 8] : src_t_data[15:8];
      assign nxt_v = exp_last ? exp_data[PAIR_W*i+24 +: 8] : src_t_data[31:24];
    end
    yuv_pair_expand #(.PAD_BYTE(PAD_BYTE)) u_expand (
      .pair   (exp_data[PAIR_W*i +: PAIR_W]),
      .nxt_u  (nxt_u),
      .nxt_v  (nxt_v),
      .interp (exp_interp),
      .px0    (exp_px[2*PX_W*i +: PX_W]),
      .px1    (exp_px[2*PX_W*i+PX_W +: PX_W])
    );
  end

  // Output register O: loads on emission, otherwise holds until the sink takes it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      dst_t_valid <= 1'b0;
      dst_t_data  <= '0;
      dst_t_last  <= 1'b0;
      dst_t_user  <= '0;
      dst_t_dest  <= '0;
    end else if (o_load) begin
      dst_t_valid <= 1'b1;
      dst_t_data  <= exp_px;
      dst_t_last  <= exp_last;
      dst_t_user  <= exp_user >> 1;
      dst_t_dest  <= exp_user[0] ? DEST_WIDTH'(CHAIN_ID) : '0;
    end else if (dst_t_ready) begin
      dst_t_valid <= 1'b0;
    end
  end

  // Hold register H: captures every accepted beat that does not bypass straight to O.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      hold_vld <= 1'b0;
      h_data   <= '0;
      h_last   <= 1'b0;
      h_user   <= '0;
    end else if (h_load) begin
      hold_vld <= 1'b1;
      h_data   <= src_t_data;
      h_last   <= src_t_last;
      h_user   <= src_t_user;
    end else if (h_move) begin
      hold_vld <= 1'b0;
    end
  end

  // Mode latch: the chroma mode is frozen at the first beat of each line.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q     <= 1'b0;
      line_start <= 1'b1;
    end else if (src_fire) begin
      if (line_start) begin
        mode_q <= interp_en;
      end
      line_start <= src_t_last;
    end
  end

  a_full_beat: assert property (@(posedge aclk) disable iff (!aresetn)
                 src_fire |-> (&src_t_strb && &src_t_keep))
    else $error("partial src beat accepted");

endmodule

// File: tb/tb_yuv422to444_stream.sv
// tb/tb_yuv422to444_stream.sv - scoreboard bench for yuv422to444_stream
module tb_yuv422to444_stream;

  localparam logic [7:0] PAD = 8'h00;

  logic        aclk        = 1'b0;
  logic        aresetn     = 1'b0;
  logic        interp_en   = 1'b0;
  logic [31:0] src_t_data  = '0;
  logic [3:0]  src_t_strb  = '1;
  logic [3:0]  src_t_keep  = '1;
  logic        src_t_last  = 1'b0;
  logic [1:0]  src_t_user  = '0;
  logic        src_t_valid = 1'b0;
  logic        src_t_ready;
  logic [63:0] dst_t_data;
  logic [7:0]  dst_t_strb;
  logic [7:0]  dst_t_keep;
  logic        dst_t_last;
  logic [1:0]  dst_t_user;
  logic [2:0]  dst_t_dest;
  logic        dst_t_valid;
  logic        dst_t_ready = 1'b0;

  int   checks = 0;
  int   errors = 0;
  bit   bp_en  = 1'b0;
  logic rdy_val = 1'b1;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  user;
    logic [2:0]  dest;
  } exp_t;

  exp_t sb[$];
  exp_t snap;
  bit   stalled = 1'b0;

  yuv422to444_stream #(
    .DATA_WIDTH (32),
    .USER_WIDTH (2),
    .DEST_WIDTH (3),
    .CHAIN_ID   (5),
    .PAD_BYTE   (PAD)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .interp_en   (interp_en),
    .src_t_data  (src_t_data),
    .src_t_strb  (src_t_strb),
    .src_t_keep  (src_t_keep),
    .src_t_last  (src_t_last),
    .src_t_user  (src_t_user),
    .src_t_valid (src_t_valid),
    .src_t_ready (src_t_ready),
    .dst_t_data  (dst_t_data),
    .dst_t_strb  (dst_t_strb),
    .dst_t_keep  (dst_t_keep),
    .dst_t_last  (dst_t_last),
    .dst_t_user  (dst_t_user),
    .dst_t_dest  (dst_t_dest),
    .dst_t_valid (dst_t_valid),
    .dst_t_ready (dst_t_ready)
  );

  always #5 aclk = ~aclk;

  // Sink readiness: either a fixed level or random with 30% ready.
  always @(posedge aclk) begin
    #1;
    dst_t_ready = bp_en ? ($urandom_range(0, 99) < 30) : rdy_val;
  end

  // Scoreboard: compare each transferred beat in order, and hold stability while stalled.
  always @(negedge aclk) begin
    exp_t cur;
    exp_t e;
    cur = {dst_t_data, dst_t_last, dst_t_user, dst_t_dest};
    if (!aresetn) begin
      stalled = 1'b0;
    end else if (!dst_t_valid) begin
      if (stalled) begin
        checks++;
        errors++;
        $display("FAIL valid_hold got 0 want 1");
        stalled = 1'b0;
      end
    end else begin
      if (stalled) begin
        checks++;
        if (cur !== snap) begin
          errors++;
          $display("FAIL stall_stable got %h want %h", cur, snap);
        end
      end
      if (dst_t_ready) begin
        stalled = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h want none", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat got %h want %h", cur, e);
          end
        end
      end else begin
        stalled = 1'b1;
        snap    = cur;
      end
    end
  end

  function automatic logic [63:0] exp_beat(input logic [31:0] d, input logic [7:0] nu,
                                           input logic [7:0] nv, input bit interp);
    logic [8:0] su;
    logic [8:0] sv;
    logic [7:0] u1;
    logic [7:0] v1;
    su = {1'b0, d[15:8]} + {1'b0, nu} + 9'd1;
    sv = {1'b0, d[31:24]} + {1'b0, nv} + 9'd1;
    u1 = interp ? su[8:1] : d[15:8];
    v1 = interp ? sv[8:1] : d[31:24];
    return {PAD, d[23:16], u1, v1, PAD, d[7:0], d[15:8], d[31:24]};
  endfunction

  task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] user);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    src_t_data  = d;
    src_t_last  = last;
    src_t_user  = user;
    src_t_valid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      done = src_t_ready;
      @(posedge aclk);
      #1;
      n++;
      if (!done && n > 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got no accept want accept");
        done = 1'b1;
      end
    end
    src_t_valid = 1'b0;
  endtask

  task automatic run_line(input int n, input bit interp, input logic [1:0] user,
                          input bit gaps, input bit toggle);
    logic [31:0] d[$];
    logic [7:0]  nu;
    logic [7:0]  nv;
    exp_t        e;
    for (int i = 0; i < n; i++) d.push_back($urandom());
    for (int b = 0; b < n; b++) begin
      nu     = (b < n - 1) ? d[b+1][15:8]  : d[b][15:8];
      nv     = (b < n - 1) ? d[b+1][31:24] : d[b][31:24];
      e.data = exp_beat(d[b], nu, nv, interp);
      e.last = (b == n - 1);
      e.user = {1'b0, user[1]};
      e.dest = user[0] ? 3'd5 : 3'd0;
      sb.push_back(e);
    end
    for (int b = 0; b < n; b++) begin
      interp_en = (toggle && b >= 2) ? !interp : interp;
      send_beat(d[b], b == n - 1, user);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || dst_t_valid) && n < 20000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || dst_t_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_%s got %0d pending want 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if (dst_t_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", dst_t_valid); end
    checks++;
    if (dst_t_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", dst_t_last); end
    checks++;
    if (dst_t_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", dst_t_data); end
    checks++;
    if (src_t_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", src_t_ready); end
    checks++;
    if ({dst_t_strb, dst_t_keep} !== 16'hFFFF) begin
      errors++;
      $display("FAIL strb_keep got %h want ffff", {dst_t_strb, dst_t_keep});
    end
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_replicate_single();
    interp_en = 1'b0;
    rdy_val   = 1'b1;
    @(posedge aclk);
    #1;
    sb.push_back({64'h00302040_00102040, 1'b1, 2'b00, 3'd0});
    checks++;
    if (dst_t_valid !== 1'b0) begin errors++; $display("FAIL rep_pre_valid got %b want 0", dst_t_valid); end
    send_beat(32'h40302010, 1'b1, 2'b00);
    checks++;
    if (dst_t_valid !== 1'b1) begin errors++; $display("FAIL rep_latency got %b want 1", dst_t_valid); end
    checks++;
    if (dst_t_data !== 64'h00302040_00102040) begin
      errors++;
      $display("FAIL rep_data got %h want 0030204000102040", dst_t_data);
    end
    wait_drain("replicate");
  endtask

  task automatic test_interpolate();
    sb.push_back({64'h00B11222_00A01020, 1'b0, 2'b00, 3'd0});
    sb.push_back({64'h00B31324_00A21324, 1'b1, 2'b00, 3'd0});
    interp_en = 1'b1;
    send_beat(32'h20B110A0, 1'b0, 2'b00);
    interp_en = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    checks++;
    if (dst_t_valid !== 1'b0) begin errors++; $display("FAIL interp_wait got %b want 0", dst_t_valid); end
    send_beat(32'h24B313A2, 1'b1, 2'b00);
    wait_drain("interpolate");
  endtask

  task automatic test_sideband();
    interp_en = 1'b0;
    sb.push_back({64'h00302040_00102040, 1'b1, 2'b01, 3'd5});
    send_beat(32'h40302010, 1'b1, 2'b11);
    checks++;
    if ({dst_t_user, dst_t_dest} !== {2'b01, 3'd5}) begin
      errors++;
      $display("FAIL side_u3 got %b/%0d want 01/5", dst_t_user, dst_t_dest);
    end
    sb.push_back({64'h00302040_00102040, 1'b1, 2'b01, 3'd0});
    send_beat(32'h40302010, 1'b1, 2'b10);
    checks++;
    if ({dst_t_user, dst_t_dest} !== {2'b01, 3'd0}) begin
      errors++;
      $display("FAIL side_u2 got %b/%0d want 01/0", dst_t_user, dst_t_dest);
    end
    run_line(3, 1'b1, 2'b01, 1'b0, 1'b0);
    wait_drain("sideband");
  endtask

  task automatic test_mode_change();
    run_line(5, 1'b0, 2'b00, 1'b0, 1'b1);
    run_line(3, 1'b1, 2'b00, 1'b0, 1'b0);
    run_line(5, 1'b1, 2'b10, 1'b0, 1'b1);
    run_line(3, 1'b0, 2'b00, 1'b0, 1'b0);
    wait_drain("mode_change");
  endtask

  task automatic test_back_to_back();
    rdy_val = 1'b1;
    for (int k = 0; k < 6; k++) run_line(4, k[0], 2'b00, 1'b0, 1'b0);
    wait_drain("back_to_back");
  endtask

  task automatic test_backpressure();
    int total;
    int n;
    total = 0;
    bp_en = 1'b1;
    while (total < 1000) begin
      n = $urandom_range(1, 6);
      run_line(n, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      total += n;
    end
    wait_drain("backpressure");
    bp_en = 1'b0;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset_midframe();
    rdy_val   = 1'b0;
    interp_en = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end
    send_beat(32'h11111111, 1'b0, 2'b00);
    send_beat(32'h22222222, 1'b0, 2'b00);
    src_t_data  = 32'h33333333;
    src_t_last  = 1'b0;
    src_t_valid = 1'b1;
    @(negedge aclk);
    checks++;
    if ({src_t_ready, dst_t_valid} !== 2'b01) begin
      errors++;
      $display("FAIL full_state got ready=%b valid=%b want 0/1", src_t_ready, dst_t_valid);
    end
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    checks++;
    if (dst_t_valid !== 1'b0) begin errors++; $display("FAIL async_reset got %b want 0", dst_t_valid); end
    checks++;
    if (src_t_ready !== 1'b1) begin errors++; $display("FAIL reset_hold got %b want 1", src_t_ready); end
    src_t_valid = 1'b0;
    interp_en   = 1'b1;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rdy_val = 1'b1;
    repeat (4) begin @(posedge aclk); #1; end
    checks++;
    if (dst_t_valid !== 1'b0) begin errors++; $display("FAIL stale_beat got %b want 0", dst_t_valid); end
    run_line(2, 1'b1, 2'b00, 1'b0, 1'b0);
    wait_drain("after_reset");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_replicate_single();
    test_interpolate();
    test_sideband();
    test_mode_change();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
